// File: rtl/mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_responder
// Purpose  : Memory-side responder for a multicycle control unit. Accepts one
//            MemRead or MemWrite request, waits WAIT_CYCLES wait states, then
//            performs the access on an internal word RAM and pulses MemReady.
// Ports    : Clk, RST (sync, active-high)
//            MemRead, MemWrite  request strobes (level-sampled in IDLE only)
//            Addr, WriteData    latched when a request is accepted
//            ReadData           registered load data, held until next read
//            MemReady           one-cycle pulse when the access completes
//            Busy               high whenever the responder is not idle
//            AccessErr          one-cycle pulse for simultaneous strobes
// Revision : 1.0  initial release
// ============================================================================
module mem_access_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              Busy,
    output logic              AccessErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              r_state_q, w_state_d;
    logic [3:0]          r_cnt_q, w_cnt_d;
    logic                r_arm_q, w_arm_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
    logic [DATA_W-1:0]   r_data_q, w_data_d;
    logic                r_is_write_q, w_is_write_d;
    logic [DATA_W-1:0]   r_rdata_q, w_rdata_d;
    logic                r_err_q, w_err_d;

    logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   w_ram_rd;

    assign w_ram_rd  = r_mem[r_addr_q];
    assign ReadData  = r_rdata_q;
    assign AccessErr = r_err_q;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_arm_d      = r_arm_q;
        w_addr_d     = r_addr_q;
        w_data_d     = r_data_q;
        w_is_write_d = r_is_write_q;
        w_rdata_d    = r_rdata_q;
        w_err_d      = 1'b0;
        MemReady     = 1'b0;
        Busy         = 1'b0;

        // Re-arm on any idle-strobe edge, in any state; a held strobe
        // therefore cannot trigger a second access.
        if (!MemRead && !MemWrite) begin
            w_arm_d = 1'b1;
        end

        case (r_state_q)
            S_IDLE: begin
                if (r_arm_q) begin
                    if (MemRead ^ MemWrite) begin
                        w_addr_d     = Addr;
                        w_data_d     = WriteData;
                        w_is_write_d = MemWrite;
                        w_arm_d      = 1'b0;
                        w_cnt_d      = c_WAIT_INIT;
                        w_state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end else if (MemRead && MemWrite) begin
                        w_err_d = 1'b1;
                        w_arm_d = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                Busy = 1'b1;
                if (r_cnt_q == 4'd0) begin
                    w_state_d = S_ACCESS;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                Busy = 1'b1;
                if (!r_is_write_q) begin
                    w_rdata_d = w_ram_rd;
                end
                w_state_d = S_RESP;
            end
            S_RESP: begin
                Busy      = 1'b1;
                MemReady  = 1'b1;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state_q    <= S_IDLE;
            r_cnt_q      <= 4'd0;
            r_arm_q      <= 1'b1;
            r_addr_q     <= '0;
            r_data_q     <= '0;
            r_is_write_q <= 1'b0;
            r_rdata_q    <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_arm_q      <= w_arm_d;
            r_addr_q     <= w_addr_d;
            r_data_q     <= w_data_d;
            r_is_write_q <= w_is_write_d;
            r_rdata_q    <= w_rdata_d;
            r_err_q      <= w_err_d;
        end
    end

    // RAM contents survive reset; a reset on the access edge cancels the store.
    always_ff @(posedge Clk) begin
        if (!RST && (r_state_q == S_ACCESS) && r_is_write_q) begin
            r_mem[r_addr_q] <= r_data_q;
        end
    end

endmodule
`default_nettype wire
